// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider (N >= 2) with edge strobes, deferred divisor loads and a graceful stop.
// All outputs are registered and update one clk_in edge after the inputs that cause them; there is no backpressure.
module clock_divider_prog #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 10
) (
  input  logic             clk_in,
  input  logic             nres,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             running,
  output logic             pending,
  output logic [CNT_W-1:0] div_active,
  output logic             err
);

  generate
    if (DIV_DEFAULT < 2 || longint'(DIV_DEFAULT) >= (64'd1 << CNT_W)) begin : g_bad_default
      $error("clock_divider_prog: DIV_DEFAULT must be in 2 .. 2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W:0]   ONE_X   = (CNT_W+1)'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pend_val_q;
  logic             pending_q;
  logic             clk_out_q;
  logic             tick_rise_q;
  logic             tick_fall_q;
  logic             err_q;

  logic             load_bad;
  logic             load_ok;
  logic             wrap;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   half_n;
  logic [CNT_W:0]   cnt_inc_x;
  logic [CNT_W-1:0] div_d;

  always_comb begin
    load_bad  = div_load && (div_in < TWO);
    load_ok   = div_load && !load_bad;
    wrap      = (cnt_q == (div_q - ONE));
    cnt_inc   = cnt_q + ONE;
    cnt_inc_x = {1'b0, cnt_inc};
    // High phase is ceil(N/2); the extra bit keeps N = 2^CNT_W-1 from overflowing.
    half_n    = ({1'b0, div_q} + ONE_X) >> 1;
    // Divisor for a period starting at a wrap edge: a load on this very edge beats a pending one.
    div_d     = load_ok ? div_in : (pending_q ? pend_val_q : div_q);
  end

  always_ff @(posedge clk_in or negedge nres) begin
    if (!nres) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_RST;
      pend_val_q  <= '0;
      pending_q   <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
      err_q       <= load_bad;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          pending_q <= 1'b0;
          if (load_ok) div_q <= div_in;
          if (en) begin
            state_q     <= RUN;
            clk_out_q   <= 1'b1;
            tick_rise_q <= 1'b1;
          end else begin
            clk_out_q   <= 1'b0;
          end
        end
        RUN: begin
          if (wrap) begin
            div_q     <= div_d;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            if (en) begin
              clk_out_q   <= 1'b1;
              tick_rise_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
              clk_out_q   <= 1'b0;
            end
          end else begin
            // en is deliberately ignored here so a started period always completes.
            cnt_q       <= cnt_inc;
            clk_out_q   <= (cnt_inc_x < half_n);
            tick_fall_q <= (cnt_inc_x == half_n);
            if (load_ok) begin
              pend_val_q <= div_in;
              pending_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign clk_out    = clk_out_q;
  assign tick_rise  = tick_rise_q;
  assign tick_fall  = tick_fall_q;
  assign running    = (state_q == RUN);
  assign pending    = pending_q;
  assign div_active = div_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: vector table, directed corner sequences and a randomized run against a period-queue model.
module tb_clock_divider_prog;

  logic        clk_in = 1'b0;
  logic        nres;
  logic        en;
  logic [15:0] div_in;
  logic        div_load;
  logic        clk_out, tick_rise, tick_fall, running, pending, err;
  logic [15:0] div_active;

  clock_divider_prog #(.CNT_W(16), .DIV_DEFAULT(10)) dut (
    .clk_in     (clk_in),
    .nres       (nres),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .tick_rise  (tick_rise),
    .tick_fall  (tick_fall),
    .running    (running),
    .pending    (pending),
    .div_active (div_active),
    .err        (err)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: a started period is materialised as a queue of its N per-cycle outputs.
  typedef struct {bit c; bit r; bit f;} ph_t;
  ph_t q[$];
  bit  m_run, m_pend;
  int  m_div, m_pval;
  bit  e_clk, e_rise, e_fall, e_err;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_div = 10; m_pval = 0;
    q.delete();
    e_clk = 0; e_rise = 0; e_fall = 0; e_err = 0;
  endtask

  task automatic model_edge(input bit en_v, input bit ld, input int din);
    ph_t p;
    bit  legal;
    int  h;
    legal = ld && (din >= 2);
    e_err = ld && (din < 2);
    if (m_run && q.size() > 0) begin
      p = q.pop_front();
      e_clk = p.c; e_rise = p.r; e_fall = p.f;
      if (legal) begin m_pend = 1; m_pval = din; end
    end else begin
      if (legal) m_div = din;
      else if (m_pend) m_div = m_pval;
      m_pend = 0;
      if (en_v) begin
        h = (m_div + 1) / 2;
        for (int k = 0; k < m_div; k++) begin
          p.c = (k < h); p.r = (k == 0); p.f = (k == h);
          q.push_back(p);
        end
        p = q.pop_front();
        e_clk = p.c; e_rise = p.r; e_fall = p.f;
        m_run = 1;
      end else begin
        m_run = 0; e_clk = 0; e_rise = 0; e_fall = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("clk_out",    32'(clk_out),    32'(e_clk));
    chk("tick_rise",  32'(tick_rise),  32'(e_rise));
    chk("tick_fall",  32'(tick_fall),  32'(e_fall));
    chk("running",    32'(running),    32'(m_run));
    chk("pending",    32'(pending),    32'(m_pend));
    chk("div_active", 32'(div_active), 32'(m_div));
    chk("err",        32'(err),        32'(e_err));
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge(en, div_load, int'(div_in));
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic drive(input bit e, input bit l, input int d);
    en = e; div_load = l; div_in = 16'(d);
  endtask

  // Called just after a falling edge; reset pulse lies entirely between clock edges.
  task automatic async_reset();
    #1 nres = 1'b0;
    #1;
    chk("rst.clk_out",    32'(clk_out),    32'd0);
    chk("rst.tick_rise",  32'(tick_rise),  32'd0);
    chk("rst.tick_fall",  32'(tick_fall),  32'd0);
    chk("rst.running",    32'(running),    32'd0);
    chk("rst.pending",    32'(pending),    32'd0);
    chk("rst.div_active", 32'(div_active), 32'd10);
    chk("rst.err",        32'(err),        32'd0);
    model_reset();
    #1 nres = 1'b1;
  endtask

  typedef struct {
    bit en; bit ld; int din;
    bit clk; bit rise; bit fall; bit run; bit pend; int div; bit er;
  } vec_t;
  vec_t tbl[15];

  int rises[$];
  int falls[$];
  int d0, d1;

  initial begin
    tbl[0]  = '{0,1,5, 0,0,0,0,0,5,0};
    tbl[1]  = '{0,1,1, 0,0,0,0,0,5,1};
    tbl[2]  = '{1,0,0, 1,1,0,1,0,5,0};
    tbl[3]  = '{1,0,0, 1,0,0,1,0,5,0};
    tbl[4]  = '{1,0,0, 1,0,0,1,0,5,0};
    tbl[5]  = '{1,0,0, 0,0,1,1,0,5,0};
    tbl[6]  = '{1,1,3, 0,0,0,1,1,5,0};
    tbl[7]  = '{1,1,0, 1,1,0,1,0,3,1};
    tbl[8]  = '{1,0,0, 1,0,0,1,0,3,0};
    tbl[9]  = '{1,0,0, 0,0,1,1,0,3,0};
    tbl[10] = '{0,1,2, 0,0,0,0,0,2,0};
    tbl[11] = '{1,0,0, 1,1,0,1,0,2,0};
    tbl[12] = '{0,0,0, 0,0,1,1,0,2,0};
    tbl[13] = '{0,0,0, 0,0,0,0,0,2,0};
    tbl[14] = '{0,1,7, 0,0,0,0,0,7,0};

    nres = 1'b0;
    drive(0, 0, 0);
    model_reset();
    @(negedge clk_in);
    chk("init.clk_out",    32'(clk_out),    32'd0);
    chk("init.running",    32'(running),    32'd0);
    chk("init.pending",    32'(pending),    32'd0);
    chk("init.div_active", 32'(div_active), 32'd10);
    chk("init.err",        32'(err),        32'd0);
    #1 nres = 1'b1;
    @(negedge clk_in);

    // Vector table: idle load, illegal loads, deferred load, load on wrap, N=2, stop at wrap.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].din);
      @(posedge clk_in);
      @(negedge clk_in);
      chk($sformatf("tbl[%0d].clk_out", i),    32'(clk_out),    32'(tbl[i].clk));
      chk($sformatf("tbl[%0d].tick_rise", i),  32'(tick_rise),  32'(tbl[i].rise));
      chk($sformatf("tbl[%0d].tick_fall", i),  32'(tick_fall),  32'(tbl[i].fall));
      chk($sformatf("tbl[%0d].running", i),    32'(running),    32'(tbl[i].run));
      chk($sformatf("tbl[%0d].pending", i),    32'(pending),    32'(tbl[i].pend));
      chk($sformatf("tbl[%0d].div_active", i), 32'(div_active), 32'(tbl[i].div));
      chk($sformatf("tbl[%0d].err", i),        32'(err),        32'(tbl[i].er));
    end
    drive(0, 0, 0);

    // Default divisor free-running: rise spacing and fall offset measured directly.
    async_reset();
    drive(1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (tick_rise) rises.push_back(i);
      if (tick_fall) falls.push_back(i);
    end
    d0 = (rises.size() >= 2) ? rises[1] - rises[0] : -1;
    d1 = (rises.size() >= 1 && falls.size() >= 1) ? falls[0] - rises[0] : -1;
    chk("rise_period", 32'(d0), 32'd10);
    chk("fall_offset", 32'(d1), 32'd5);
    chk("rise_count",  32'(rises.size()), 32'd3);

    // Deferred load of 4 at cnt=2, then illegal loads while running.
    async_reset();
    drive(1, 0, 0);
    repeat (3) cycle();
    drive(1, 1, 4); cycle();
    drive(1, 0, 0); repeat (12) cycle();
    drive(1, 1, 1); cycle();
    drive(1, 1, 0); cycle();
    drive(1, 0, 0); repeat (6) cycle();

    // Drop en at cnt=1 until stop; later a short en dropout mid-period.
    async_reset();
    drive(1, 0, 0); repeat (2) cycle();
    drive(0, 0, 0); repeat (12) cycle();
    drive(1, 0, 0); repeat (8) cycle();
    drive(0, 0, 0); repeat (3) cycle();
    drive(1, 0, 0); repeat (15) cycle();

    // Reset mid high phase with a pending load of 6, then restart.
    async_reset();
    drive(1, 0, 0); repeat (2) cycle();
    drive(1, 1, 6); cycle();
    drive(1, 0, 0); cycle();
    async_reset();
    repeat (22) cycle();

    // Randomized run against the model, with occasional async resets.
    async_reset();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9));
      cycle();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
